rib_ram_slave: RTL

- Responder end of the core's data-memory request interface: it accepts the single-word read and write requests that the memory-access stage issues, and services them from an on-chip word RAM.
- Adds programmable wait states and a one-cycle acknowledge pulse.
- Drives a hold back to the pipeline while a request is outstanding.
- Sits between the RIB interconnect and the data RAM macro.

---
 rtl/rib_ram_slave_pkg.sv | 26 ++
 rtl/rib_ram_array.sv | 35 +++
 rtl/rib_ram_slave.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rib_ram_slave_pkg.sv
// Shared state encodings, request/write-enable constants and the range-check helper.
// Used by both the RIB RAM responder and its word array.
package rib_ram_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic        RIB_REQ      = 1'b1;
  localparam logic        RIB_NREQ     = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  // 33-bit offset: an address below base wraps to a huge value and fails the compare.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return off < span;
  endfunction

endpackage

// File: rtl/rib_ram_array.sv
// Single-port 32-bit word RAM, synchronous write, registered read gated by re.
// Byte-lane write enables exist only when RIB_RAM_WSTRB_EN is defined.
module rib_ram_array
  import rib_ram_slave_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
`ifdef RIB_RAM_WSTRB_EN
  input  logic [3:0]               be,
`endif
  input  logic [31:0]              wdata,
  input  logic                     re,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we == WriteEnable) begin
`ifdef RIB_RAM_WSTRB_EN
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
`else
      mem[addr] <= wdata;
`endif
    end
    // Output register only moves on a read so the last read word stays visible.
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/rib_ram_slave.sv
// RIB data-memory responder: IDLE->WAIT->RESP, ack WAIT_CYCLES+1 cycles after the request cycle.
// hold_o stalls the pipeline until ack; RIB_RAM_WSTRB_EN adds byte-lane write strobes.
module rib_ram_slave
  import rib_ram_slave_pkg::*;
#(
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef RIB_RAM_WSTRB_EN
  input  logic [3:0]  wstrb_i,
`endif
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        hold_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic            cap_we;
  logic            cap_ok;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
`ifdef RIB_RAM_WSTRB_EN
  logic [3:0]      cap_strb;
`endif
  logic            rd_vld;

  logic            in_ok;
  logic [AW-1:0]   in_idx;
  logic            to_resp;
  logic            rsp_rd;
  logic            rsp_ok;
  logic            rd_fire;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_q;

  assign in_ok  = addr_in_range(addr_i, BASE_ADDR, SPAN);
  assign in_idx = AW'((addr_i - BASE_ADDR) >> 2);

  // The read must be launched on the edge entering RESP, which with zero
  // wait states is the accept edge itself, so IDLE reads use the live fields.
  always_comb begin
    to_resp = 1'b0;
    rsp_rd  = 1'b0;
    rsp_ok  = 1'b0;
    if (state == ST_IDLE && req_i == RIB_REQ && WAIT_CYCLES == 0) begin
      to_resp = 1'b1;
      rsp_rd  = ~we_i;
      rsp_ok  = in_ok;
    end else if (state == ST_WAIT && cnt == 4'd0) begin
      to_resp = 1'b1;
      rsp_rd  = ~cap_we;
      rsp_ok  = cap_ok;
    end
  end

  assign rd_fire  = to_resp & rsp_rd & rsp_ok;
  assign ram_addr = (state == ST_IDLE) ? in_idx : cap_idx;
  assign ram_we   = (state == ST_RESP && cap_we && cap_ok) ? WriteEnable : WriteDisable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      rd_vld    <= 1'b0;
      cap_we    <= 1'b0;
      cap_ok    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= ZeroWord;
`ifdef RIB_RAM_WSTRB_EN
      cap_strb  <= 4'h0;
`endif
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_i == RIB_REQ) begin
            cap_we    <= we_i;
            cap_ok    <= in_ok;
            cap_idx   <= in_idx;
            cap_wdata <= wdata_i;
`ifdef RIB_RAM_WSTRB_EN
            cap_strb  <= wstrb_i;
`endif
            cnt       <= CNT_INIT;
            state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (to_resp) begin
        ack_o <= 1'b1;
        err_o <= ~rsp_ok;
        // Writes leave the read data alone; an out-of-range read forces it to zero.
        if (rsp_rd) rd_vld <= rsp_ok;
      end
    end
  end

  rib_ram_array #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
`ifdef RIB_RAM_WSTRB_EN
    .be    (cap_strb),
`endif
    .wdata (cap_wdata),
    .re    (rd_fire),
    .rdata (ram_q)
  );

  assign rdata_o = rd_vld ? ram_q : ZeroWord;
  assign hold_o  = req_i & ~ack_o;

endmodule
